// File: rtl/stq_drain_l.sv
// stq_drain_l: in-order drain of retired store-queue entries into the L1D.
// Ports: clk/rst, stallA, passe/free flags, wr_* write handshake, free_en, head, drain_empty.
module stq_drain_l #(
  parameter int BUF_COUNT = 32,
  parameter int PTR_W     = 5,
  parameter int MAX_OUT   = 2,
  parameter int RETRY_GAP = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallA,
  input  logic [BUF_COUNT-1:0] passe,
  input  logic [BUF_COUNT-1:0] free,
  output logic                 wr_req,
  output logic [PTR_W-1:0]     wr_idx,
  input  logic                 wr_rdy,
  input  logic                 wr_ack,
  input  logic                 wr_nack,
  output logic [BUF_COUNT-1:0] free_en,
  output logic [PTR_W-1:0]     head,
  output logic                 drain_empty
);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int GW = (RETRY_GAP > 0) ? $clog2(RETRY_GAP + 1) : 1;
  localparam logic [BUF_COUNT-1:0] ONE = BUF_COUNT'(1);

  typedef enum logic {RUN, GAP} state_t;

  state_t           state;
  logic [GW-1:0]    gap_cnt;
  logic [PTR_W-1:0] iss;
  logic [OW-1:0]    outst;

  logic [PTR_W-1:0] hq;
  logic [PTR_W-1:0] iss_a;
  logic [PTR_W-1:0] iss_n;
  logic [OW:0]      outst_a;
  logic [OW-1:0]    outst_n;
  logic             run;
  logic             acc;
  logic             nk;
  logic             ak;
  logic             held;
  logic             can;
  logic             req_n;

  always_comb begin
    // head output lags the ack by a cycle; a pending
    // free_en pulse means the true oldest entry is head+1
    hq      = head + PTR_W'(|free_en);
    run     = (state == RUN);
    acc     = wr_req & wr_rdy;
    held    = wr_req & ~wr_rdy;
    nk      = run & wr_nack & (outst != '0);
    ak      = run & wr_ack & ~wr_nack & (outst != '0);
    iss_a   = iss + PTR_W'(acc);
    outst_a = {1'b0, outst} + (OW+1)'(acc) - (OW+1)'(ak);
    // a same-cycle ack frees a slot for back-to-back issue
    can     = run & ~nk & ~held & ~stallA
            & passe[iss_a] & ~free[iss_a]
            & (outst_a < (OW+1)'(MAX_OUT));
    iss_n   = nk ? hq : iss_a;
    outst_n = nk ? '0 : outst_a[OW-1:0];
    req_n   = wr_req;
    if (nk)
      req_n = 1'b0;
    else if (can)
      req_n = 1'b1;
    else if (acc)
      req_n = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      gap_cnt     <= '0;
      iss         <= '0;
      outst       <= '0;
      wr_req      <= 1'b0;
      wr_idx      <= '0;
      free_en     <= '0;
      head        <= '0;
      drain_empty <= 1'b1;
    end else begin
      iss     <= iss_n;
      outst   <= outst_n;
      wr_req  <= req_n;
      head    <= hq;
      free_en <= ak ? (ONE << hq) : '0;
      if (can)
        wr_idx <= iss_a;
      drain_empty <= (outst_n == '0) & ~req_n
                   & ~passe[iss_n];
      case (state)
        RUN: begin
          if (nk) begin
            if (RETRY_GAP > 0)
              state <= GAP;
            gap_cnt <= GW'(RETRY_GAP);
          end
        end
        GAP: begin
          if (gap_cnt <= GW'(1)) begin
            state   <= RUN;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_stq_drain_l.sv
// tb_stq_drain_l: directed bench for stq_drain_l with a queue-based model.
// Model is compared every cycle; directed scenarios add literal checks.
module tb_stq_drain_l;
  localparam int N  = 32;
  localparam int PW = 5;
  localparam int MO = 2;
  localparam int RG = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stallA = 1'b0;
  logic [N-1:0]  passe = '0;
  logic [N-1:0]  free = '0;
  logic          wr_req;
  logic [PW-1:0] wr_idx;
  logic          wr_rdy = 1'b0;
  logic          wr_ack = 1'b0;
  logic          wr_nack = 1'b0;
  logic [N-1:0]  free_en;
  logic [PW-1:0] head;
  logic          drain_empty;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stq_drain_l #(
    .BUF_COUNT(N), .PTR_W(PW),
    .MAX_OUT(MO), .RETRY_GAP(RG)
  ) dut (
    .clk(clk), .rst(rst), .stallA(stallA),
    .passe(passe), .free(free),
    .wr_req(wr_req), .wr_idx(wr_idx),
    .wr_rdy(wr_rdy), .wr_ack(wr_ack),
    .wr_nack(wr_nack), .free_en(free_en),
    .head(head), .drain_empty(drain_empty)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: outstanding writes are a queue of entry numbers;
  // the next entry to issue is always head + queue length.
  int           m_head;
  int           m_hout;
  int           m_gap;
  int           m_idx;
  bit           m_req;
  bit           m_de;
  logic [N-1:0] m_fe;
  int           q[$];

  always @(posedge clk or negedge rst) begin
    bit run, acc, nk, ak;
    int nxt, fr;
    if (!rst) begin
      m_head = 0; m_hout = 0; m_gap = 0; m_idx = 0;
      m_req = 0; m_de = 1; m_fe = '0;
      q.delete();
    end else begin
      run = (m_gap == 0);
      acc = m_req && wr_rdy;
      nk  = run && wr_nack && q.size() > 0;
      ak  = run && wr_ack && !wr_nack && q.size() > 0;
      m_hout = m_head;
      m_fe = '0;
      if (nk) begin
        q.delete();
        m_req = 0;
        m_gap = RG;
      end else begin
        if (!run) m_gap--;
        if (ak) begin
          fr = q.pop_front();
          m_fe[fr] = 1'b1;
          m_head = (fr + 1) % N;
        end
        if (acc) q.push_back(m_idx);
        nxt = (m_head + q.size()) % N;
        if (run && !(m_req && !wr_rdy) && !stallA &&
            passe[nxt] && !free[nxt] && q.size() < MO) begin
          m_req = 1;
          m_idx = nxt;
        end else if (acc) begin
          m_req = 0;
        end
      end
      nxt = (m_head + q.size()) % N;
      m_de = (q.size() == 0) && !m_req && !passe[nxt];
    end
  end

  always @(posedge clk) begin
    #1;
    chk("m_wr_req", 32'(wr_req), 32'(m_req));
    chk("m_wr_idx", 32'(wr_idx), m_idx);
    chk("m_free_en", free_en, m_fe);
    chk("m_head", 32'(head), m_hout);
    chk("m_drain_empty", 32'(drain_empty), 32'(m_de));
  end

  // Cache responder: acks each accepted write one cycle later.
  int rcnt;
  bit auto_ack = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst)
      rcnt <= 0;
    else
      rcnt <= rcnt + ((wr_req && wr_rdy) ? 1 : 0)
                   - ((wr_ack && rcnt > 0) ? 1 : 0);
  end

  // Entry array: drops passe when the entry is freed.
  task automatic tick();
    @(negedge clk);
    passe = passe & ~free_en;
    if (auto_ack) wr_ack = (rcnt > 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; passe = '0; free = '0; stallA = 1'b0;
    wr_ack = 1'b0; wr_nack = 1'b0; wr_rdy = 1'b0;
    auto_ack = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    int idxs[$];
    logic [31:0] fes[$];

    // single entry
    do_reset();
    chk("rst_req", 32'(wr_req), 0);
    chk("rst_idx", 32'(wr_idx), 0);
    chk("rst_free_en", free_en, 0);
    chk("rst_head", 32'(head), 0);
    chk("rst_empty", 32'(drain_empty), 1);
    wr_rdy = 1'b1; auto_ack = 1; passe = 32'h1;
    tick();
    chk("s1_req", 32'(wr_req), 1);
    chk("s1_idx", 32'(wr_idx), 0);
    tick();
    tick();
    chk("s1_free_en", free_en, 32'h1);
    tick();
    chk("s1_head", 32'(head), 1);
    chk("s1_empty", 32'(drain_empty), 1);
    chk("s1_free_off", free_en, 0);

    // pipelining with acks withheld
    do_reset();
    wr_rdy = 1'b1; passe = 32'hF;
    tick();
    chk("s2_req0", 32'(wr_req), 1);
    chk("s2_idx0", 32'(wr_idx), 0);
    tick();
    chk("s2_req1", 32'(wr_req), 1);
    chk("s2_idx1", 32'(wr_idx), 1);
    repeat (3) begin
      tick();
      chk("s2_cap", 32'(wr_req), 0);
    end
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("s2_free_en", free_en, 32'h1);
    chk("s2_req2", 32'(wr_req), 1);
    chk("s2_idx2", 32'(wr_idx), 2);

    // backpressure
    do_reset();
    wr_rdy = 1'b0; passe = 32'h1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s3_hold_req", 32'(wr_req), 1);
      chk("s3_hold_idx", 32'(wr_idx), 0);
    end
    wr_rdy = 1'b1;
    tick();
    chk("s3_accepted", 32'(wr_req), 0);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("s3_free_en", free_en, 32'h1);

    // nack replay
    do_reset();
    wr_rdy = 1'b1; passe = 32'h3;
    tick();
    tick();
    chk("s4_idx1", 32'(wr_idx), 1);
    tick();
    wr_nack = 1'b1;
    tick();
    wr_nack = 1'b0;
    chk("s4_no_free", free_en, 0);
    chk("s4_gap0", 32'(wr_req), 0);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("s4_gap_ack", free_en, 0);
    chk("s4_gap1", 32'(wr_req), 0);
    tick();
    chk("s4_gap2", 32'(wr_req), 0);
    tick();
    chk("s4_gap3", 32'(wr_req), 0);
    tick();
    chk("s4_reissue", 32'(wr_req), 1);
    chk("s4_reidx", 32'(wr_idx), 0);
    chk("s4_head", 32'(head), 0);

    // throughput then wrap-around
    do_reset();
    wr_rdy = 1'b1; auto_ack = 1; passe = 32'h7FFF_FFFF;
    n = 0;
    while (head != 5'd31 && n < 80) begin
      tick();
      n++;
    end
    chk("s5_reach", 32'(head), 31);
    chk("s5_rate", 32'(n <= 40), 1);
    passe = 32'h8000_0001;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wr_req) idxs.push_back(int'(wr_idx));
      if (free_en != '0) fes.push_back(free_en);
    end
    chk("s5_nreq", idxs.size(), 2);
    chk("s5_idx_a", (idxs.size() > 0) ? idxs[0] : -1, 31);
    chk("s5_idx_b", (idxs.size() > 1) ? idxs[1] : -1, 0);
    chk("s5_nfree", fes.size(), 2);
    chk("s5_fe_a", (fes.size() > 0) ? fes[0] : '0, 32'h8000_0000);
    chk("s5_fe_b", (fes.size() > 1) ? fes[1] : '0, 32'h1);
    chk("s5_head", 32'(head), 1);

    // stall, then reset with two outstanding
    do_reset();
    wr_rdy = 1'b1; stallA = 1'b1; passe = 32'h1;
    repeat (4) begin
      tick();
      chk("s6_stall", 32'(wr_req), 0);
    end
    chk("s6_busy", 32'(drain_empty), 0);
    stallA = 1'b0; passe = 32'h3;
    tick();
    chk("s6_req0", 32'(wr_idx), 0);
    tick();
    chk("s6_req1", 32'(wr_idx), 1);
    tick();
    chk("s6_full", 32'(wr_req), 0);
    rst = 1'b0;
    #1;
    chk("s6_rst_req", 32'(wr_req), 0);
    chk("s6_rst_idx", 32'(wr_idx), 0);
    chk("s6_rst_fe", free_en, 0);
    chk("s6_rst_head", 32'(head), 0);
    chk("s6_rst_empty", 32'(drain_empty), 1);
    tick();
    rst = 1'b1; passe = '0; wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("s6_late_ack", free_en, 0);
    tick();
    chk("s6_late_fe", free_en, 0);
    chk("s6_late_head", 32'(head), 0);
    chk("s6_late_empty", 32'(drain_empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
